transpose_stream_sink: RTL and testbench

Receiving end of the two-lane transpose stream. Captures bursts of BLOCK_LEN beats presented as lane0/lane1 pairs with an enable strobe, such as the output of the transpose stage, into a ping-pong pair of banks. Drains each completed block as a single-lane valid/ready stream: all of lane 0 in arrival order, then all of lane 1. Sits between the transpose pipeline and the downstream packer/DMA, and absorbs output backpressure for up to one queued block.

---
 rtl/transpose_stream_sink_pkg.sv | 26 ++
 rtl/transpose_stream_sink_if.sv | 36 +++
 rtl/transpose_stream_sink_bank.sv | 39 +++
 rtl/transpose_stream_sink.sv | 216 +++++++++++++++++++++
 tb/tb_transpose_stream_sink.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/transpose_stream_sink_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : transpose_pkg
//  Description : Shared types and sizing helpers for the transpose stream
//                sink. Optional statistics are controlled by the macro
//                TRANSPOSE_SINK_STATS_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
package transpose_pkg;

    localparam int DEFAULT_VALUE_WIDTH = 17;
    localparam int DEFAULT_BLOCK_LEN   = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRAIN0 = 2'd1,
        DRAIN1 = 2'd2
    } sink_state_t;

    // Width of a beat/read index; BLOCK_LEN is a power of two >= 2.
    function automatic int cnt_width(input int block_len);
        return (block_len > 1) ? $clog2(block_len) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/transpose_stream_sink_if.sv
`default_nettype none
// ============================================================================
//  Module      : transpose_stream_sink_if
//  Description : Two-lane input strobe plus single-lane valid/ready output
//                bundle of the transpose stream sink.
//  Revision    : 1.0 - initial release
// ============================================================================
interface transpose_stream_sink_if
    import transpose_pkg::*;
#(
    parameter int VALUE_WIDTH = DEFAULT_VALUE_WIDTH
) ();

    logic                   i_enable;
    logic [VALUE_WIDTH-1:0] i_in0;
    logic [VALUE_WIDTH-1:0] i_in1;
    logic                   i_ready;
    logic                   o_valid;
    logic [VALUE_WIDTH-1:0] o_data;
    logic                   o_last;
    logic                   o_overflow;

    // Environment side: produces beats and output acceptance.
    modport master (
        output i_enable, i_in0, i_in1, i_ready,
        input  o_valid, o_data, o_last, o_overflow
    );

    // Sink side.
    modport slave (
        input  i_enable, i_in0, i_in1, i_ready,
        output o_valid, o_data, o_last, o_overflow
    );

endinterface
`default_nettype wire

// File: rtl/transpose_stream_sink_bank.sv
`default_nettype none
// ============================================================================
//  Module      : transpose_sink_bank
//  Description : One 2 x BLOCK_LEN value bank. Both lanes are written
//                together at one index; read is combinational by lane/index.
//  Revision    : 1.0 - initial release
// ============================================================================
module transpose_sink_bank
    import transpose_pkg::*;
#(
    parameter int VALUE_WIDTH = DEFAULT_VALUE_WIDTH,
    parameter int BLOCK_LEN   = DEFAULT_BLOCK_LEN,
    localparam int CW         = cnt_width(BLOCK_LEN)
) (
    input  wire logic                   i_clk,
    input  wire logic                   i_we,
    input  wire logic [CW-1:0]          i_widx,
    input  wire logic [VALUE_WIDTH-1:0] i_lane0,
    input  wire logic [VALUE_WIDTH-1:0] i_lane1,
    input  wire logic                   i_rlane,
    input  wire logic [CW-1:0]          i_ridx,
    output logic      [VALUE_WIDTH-1:0] o_rdata
);

    logic [VALUE_WIDTH-1:0] lane0_q [BLOCK_LEN];
    logic [VALUE_WIDTH-1:0] lane1_q [BLOCK_LEN];

    // Storage needs no reset: validity is tracked by the parent's full flags.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            lane0_q[i_widx] <= i_lane0;
            lane1_q[i_widx] <= i_lane1;
        end
    end

    assign o_rdata = i_rlane ? lane1_q[i_ridx] : lane0_q[i_ridx];

endmodule
`default_nettype wire

// File: rtl/transpose_stream_sink.sv
`default_nettype none
// ============================================================================
//  Module      : transpose_stream_sink
//  Description : Captures BLOCK_LEN two-lane beats into ping-pong banks and
//                drains each block as lane 0 then lane 1 on a valid/ready
//                stream. Define TRANSPOSE_SINK_STATS_EN to add the
//                o_blocks_done / o_dropped_beats counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module transpose_stream_sink
    import transpose_pkg::*;
#(
    parameter int VALUE_WIDTH = DEFAULT_VALUE_WIDTH,
    parameter int BLOCK_LEN   = DEFAULT_BLOCK_LEN
) (
    input  wire logic               i_clk,
    input  wire logic               i_aresetn,
    transpose_stream_sink_if.slave  s_if
`ifdef TRANSPOSE_SINK_STATS_EN
    ,
    output logic [15:0]             o_blocks_done,
    output logic [15:0]             o_dropped_beats
`endif
);

    localparam int          CW        = cnt_width(BLOCK_LEN);
    localparam logic [CW-1:0] C_IDX_MAX = CW'(BLOCK_LEN - 1);

    sink_state_t            state_q, state_d;
    logic [1:0]             full_q, full_d, full_set, full_clr;
    logic                   wr_bank_q, wr_bank_d;
    logic                   rd_bank_q, rd_bank_d;
    logic [CW-1:0]          beat_cnt_q, beat_cnt_d;
    logic [CW-1:0]          rd_idx_q, rd_idx_d;
    logic                   valid_q, valid_d;
    logic [VALUE_WIDTH-1:0] data_q, data_d;
    logic                   last_q, last_d;
    logic                   overflow_q, overflow_d;

    logic                   w_accept, w_drop, w_hs;
    logic                   w_we0, w_we1;
    logic                   w_rd_sel, w_rd_lane;
    logic [CW-1:0]          w_rd_addr, w_next_idx;
    logic [VALUE_WIDTH-1:0] w_rdata0, w_rdata1, w_rdata;

    transpose_sink_bank #(.VALUE_WIDTH(VALUE_WIDTH), .BLOCK_LEN(BLOCK_LEN)) u_bank0 (
        .i_clk(i_clk), .i_we(w_we0), .i_widx(beat_cnt_q),
        .i_lane0(s_if.i_in0), .i_lane1(s_if.i_in1),
        .i_rlane(w_rd_lane), .i_ridx(w_rd_addr), .o_rdata(w_rdata0)
    );

    transpose_sink_bank #(.VALUE_WIDTH(VALUE_WIDTH), .BLOCK_LEN(BLOCK_LEN)) u_bank1 (
        .i_clk(i_clk), .i_we(w_we1), .i_widx(beat_cnt_q),
        .i_lane0(s_if.i_in0), .i_lane1(s_if.i_in1),
        .i_rlane(w_rd_lane), .i_ridx(w_rd_addr), .o_rdata(w_rdata1)
    );

    assign w_rdata  = w_rd_sel ? w_rdata1 : w_rdata0;
    assign w_hs     = valid_q & s_if.i_ready;
    // A beat only sees the full flag as it was before the edge.
    assign w_accept = s_if.i_enable & ~full_q[wr_bank_q];
    assign w_drop   = s_if.i_enable &  full_q[wr_bank_q];
    // Separate set/clear terms so completing and freeing on one edge both land.
    assign full_d   = (full_q & ~full_clr) | full_set;

    // Input path: write beats into the current bank, close it on the last beat.
    always_comb begin
        beat_cnt_d = beat_cnt_q;
        wr_bank_d  = wr_bank_q;
        full_set   = 2'b00;
        overflow_d = overflow_q | w_drop;
        w_we0      = w_accept & ~wr_bank_q;
        w_we1      = w_accept &  wr_bank_q;
        if (w_accept) begin
            if (beat_cnt_q == C_IDX_MAX) begin
                full_set[wr_bank_q] = 1'b1;
                wr_bank_d           = ~wr_bank_q;
                beat_cnt_d          = '0;
            end else begin
                beat_cnt_d = beat_cnt_q + CW'(1);
            end
        end
    end

    // Output FSM: next state, bank read address and registered output word.
    always_comb begin
        state_d    = state_q;
        rd_idx_d   = rd_idx_q;
        rd_bank_d  = rd_bank_q;
        valid_d    = valid_q;
        data_d     = data_q;
        last_d     = last_q;
        full_clr   = 2'b00;
        w_rd_sel   = rd_bank_q;
        w_rd_lane  = 1'b0;
        w_rd_addr  = '0;
        w_next_idx = rd_idx_q + CW'(1);
        unique case (state_q)
            IDLE: begin
                if (full_q[rd_bank_q]) begin
                    data_d   = w_rdata;
                    valid_d  = 1'b1;
                    last_d   = 1'b0;
                    rd_idx_d = '0;
                    state_d  = DRAIN0;
                end
            end
            DRAIN0: begin
                if (w_hs) begin
                    if (rd_idx_q == C_IDX_MAX) begin
                        w_rd_lane = 1'b1;
                        rd_idx_d  = '0;
                        state_d   = DRAIN1;
                    end else begin
                        w_rd_addr = w_next_idx;
                        rd_idx_d  = w_next_idx;
                    end
                    data_d = w_rdata;
                end
            end
            DRAIN1: begin
                if (w_hs) begin
                    if (rd_idx_q == C_IDX_MAX) begin
                        full_clr[rd_bank_q] = 1'b1;
                        rd_bank_d           = ~rd_bank_q;
                        rd_idx_d            = '0;
                        last_d              = 1'b0;
                        if (full_q[~rd_bank_q]) begin
                            // Chain straight into the queued block, no bubble.
                            w_rd_sel = ~rd_bank_q;
                            data_d   = w_rdata;
                            valid_d  = 1'b1;
                            state_d  = DRAIN0;
                        end else begin
                            data_d  = '0;
                            valid_d = 1'b0;
                            state_d = IDLE;
                        end
                    end else begin
                        w_rd_lane = 1'b1;
                        w_rd_addr = w_next_idx;
                        rd_idx_d  = w_next_idx;
                        data_d    = w_rdata;
                        last_d    = (w_next_idx == C_IDX_MAX);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_aresetn) begin
            state_q    <= IDLE;
            full_q     <= 2'b00;
            wr_bank_q  <= 1'b0;
            rd_bank_q  <= 1'b0;
            beat_cnt_q <= '0;
            rd_idx_q   <= '0;
            valid_q    <= 1'b0;
            data_q     <= '0;
            last_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            full_q     <= full_d;
            wr_bank_q  <= wr_bank_d;
            rd_bank_q  <= rd_bank_d;
            beat_cnt_q <= beat_cnt_d;
            rd_idx_q   <= rd_idx_d;
            valid_q    <= valid_d;
            data_q     <= data_d;
            last_q     <= last_d;
            overflow_q <= overflow_d;
        end
    end

    assign s_if.o_valid    = valid_q;
    assign s_if.o_data     = data_q;
    assign s_if.o_last     = last_q;
    assign s_if.o_overflow = overflow_q;

`ifdef TRANSPOSE_SINK_STATS_EN
    logic [15:0] blocks_done_q, blocks_done_d;
    logic [15:0] dropped_q, dropped_d;

    // Block counter wraps; drop counter saturates.
    always_comb begin
        blocks_done_d = blocks_done_q;
        dropped_d     = dropped_q;
        if (w_hs && last_q) begin
            blocks_done_d = blocks_done_q + 16'd1;
        end
        if (w_drop && (dropped_q != 16'hFFFF)) begin
            dropped_d = dropped_q + 16'd1;
        end
    end

    // Statistics registers.
    always_ff @(posedge i_clk) begin
        if (!i_aresetn) begin
            blocks_done_q <= '0;
            dropped_q     <= '0;
        end else begin
            blocks_done_q <= blocks_done_d;
            dropped_q     <= dropped_d;
        end
    end

    assign o_blocks_done   = blocks_done_q;
    assign o_dropped_beats = dropped_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_transpose_stream_sink.sv
`default_nettype none
// ============================================================================
//  Module      : tb_transpose_stream_sink
//  Description : Directed self-checking bench for transpose_stream_sink
//                (BLOCK_LEN=4, VALUE_WIDTH=17).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_transpose_stream_sink;

    localparam int VW = 17;
    localparam int BL = 4;

    logic clk = 1'b0;
    logic aresetn;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    transpose_stream_sink_if #(.VALUE_WIDTH(VW)) s_if ();

`ifdef TRANSPOSE_SINK_STATS_EN
    logic [15:0] blocks_done;
    logic [15:0] dropped_beats;
`endif

    transpose_stream_sink #(.VALUE_WIDTH(VW), .BLOCK_LEN(BL)) dut (
        .i_clk          (clk),
        .i_aresetn      (aresetn),
        .s_if           (s_if)
`ifdef TRANSPOSE_SINK_STATS_EN
        ,
        .o_blocks_done  (blocks_done),
        .o_dropped_beats(dropped_beats)
`endif
    );

    // Stimulus schedule and scoreboard.
    int           feed_c[$];
    logic [VW-1:0] feed_a[$];
    logic [VW-1:0] feed_b[$];
    logic [VW-1:0] exp_q[$];
    logic [VW-1:0] got[$];
    logic         got_last[$];
    int           stable_err;
    int           bubbles;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Block 0 uses the hand-written vectors; others use a simple tagged pattern.
    function automatic logic [VW-1:0] blk_val(input int b, input int lane, input int i);
        logic [VW-1:0] l0 [4];
        logic [VW-1:0] l1 [4];
        l0[0] = 17'h0ABAB; l0[1] = 17'h0CDCD; l0[2] = 17'h0EFEF; l0[3] = 17'h00101;
        l1[0] = 17'h02323; l1[1] = 17'h04545; l1[2] = 17'h06767; l1[3] = 17'h08989;
        if (b == 0) return (lane == 0) ? l0[i] : l1[i];
        return (lane == 0) ? VW'(32'h10000 + b * 256 + i) : VW'(32'h00800 + b * 256 + i);
    endfunction

    // Schedule a block's beats from cycle 'start' (negative: no feed) and
    // optionally append its eight expected words.
    task automatic add_block(input int b, input int start, input int gap, input bit keep);
        for (int i = 0; i < BL; i++) begin
            if (start >= 0) begin
                feed_c.push_back(start + i * (gap + 1));
                feed_a.push_back(blk_val(b, 0, i));
                feed_b.push_back(blk_val(b, 1, i));
            end
        end
        if (keep) begin
            for (int i = 0; i < BL; i++) exp_q.push_back(blk_val(b, 0, i));
            for (int i = 0; i < BL; i++) exp_q.push_back(blk_val(b, 1, i));
        end
    endtask

    // Run until 'want' words are accepted and all beats fed, or the budget ends.
    // pat: 0 = ready high, 1 = ready 1,0,0 repeating, 2 = ready low.
    task automatic drain(input int pat, input int want, input int max_cyc);
        int            c;
        bit            rdy, started, prev_stall;
        logic [VW-1:0] pd;
        logic          pl;
        got.delete(); got_last.delete();
        stable_err = 0; bubbles = 0; started = 0; prev_stall = 0; c = 0;
        pd = '0; pl = 1'b0;
        while ((got.size() < want || feed_c.size() > 0) && c < max_cyc) begin
            if (feed_c.size() > 0 && feed_c[0] <= c) begin
                s_if.i_enable = 1'b1;
                s_if.i_in0    = feed_a.pop_front();
                s_if.i_in1    = feed_b.pop_front();
                void'(feed_c.pop_front());
            end else begin
                s_if.i_enable = 1'b0;
            end
            if (prev_stall && (s_if.o_data !== pd || s_if.o_last !== pl || s_if.o_valid !== 1'b1))
                stable_err++;
            if (started && !s_if.o_valid && got.size() < want) bubbles++;
            rdy = (pat == 0) ? 1'b1 : (pat == 1) ? ((c % 3) == 0) : 1'b0;
            s_if.i_ready = rdy;
            if (s_if.o_valid) started = 1'b1;
            if (s_if.o_valid && rdy) begin
                got.push_back(s_if.o_data);
                got_last.push_back(s_if.o_last);
            end
            prev_stall = s_if.o_valid && !rdy;
            pd = s_if.o_data;
            pl = s_if.o_last;
            tick();
            c++;
        end
        s_if.i_enable = 1'b0;
        feed_c.delete(); feed_a.delete(); feed_b.delete();
    endtask

    task automatic compare(input string name);
        chk({name, "_count"}, got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            chk($sformatf("%s_w%0d", name, i), (i < got.size()) ? 32'(got[i]) : 32'hFFFF_FFFF, 32'(exp_q[i]));
            chk($sformatf("%s_last%0d", name, i), (i < got.size()) ? 32'(got_last[i]) : 32'hFFFF_FFFF,
                32'((i % 8) == 7));
        end
        exp_q.delete();
    endtask

    initial begin
        aresetn       = 1'b0;
        s_if.i_enable = 1'b0;
        s_if.i_in0    = '0;
        s_if.i_in1    = '0;
        s_if.i_ready  = 1'b0;
        tick();
        tick();
        chk("rst_valid", s_if.o_valid, 0);
        chk("rst_data", s_if.o_data, 0);
        chk("rst_last", s_if.o_last, 0);
        chk("rst_overflow", s_if.o_overflow, 0);
        aresetn = 1'b1;

        // Single block with latency check.
        for (int i = 0; i < BL; i++) begin
            s_if.i_enable = 1'b1;
            s_if.i_in0    = blk_val(0, 0, i);
            s_if.i_in1    = blk_val(0, 1, i);
            tick();
        end
        chk("lat_after_E", s_if.o_valid, 0);
        s_if.i_enable = 1'b0;
        s_if.i_ready  = 1'b1;
        tick();
        chk("lat_after_E1_valid", s_if.o_valid, 1);
        chk("lat_after_E1_data", s_if.o_data, 32'h0ABAB);
        add_block(0, -1, 0, 1'b1);
        drain(0, 8, 40);
        compare("single");
        chk("single_bubbles", bubbles, 0);
        chk("single_idle", s_if.o_valid, 0);
        chk("single_idle_data", s_if.o_data, 0);

        // Backpressure 1,0,0 pattern.
        add_block(0, 0, 0, 1'b1);
        drain(1, 8, 80);
        compare("bp");
        chk("bp_stable", stable_err, 0);

        // Three back-to-back blocks; third waits for bank 0 to free.
        add_block(4, 0, 0, 1'b1);
        add_block(5, 4, 0, 1'b1);
        add_block(6, 13, 0, 1'b1);
        drain(0, 24, 80);
        compare("b2b");
        chk("b2b_bubbles", bubbles, 0);
        chk("b2b_overflow", s_if.o_overflow, 0);

        // Gapped input: two idle cycles between beats.
        add_block(0, 0, 2, 1'b1);
        drain(0, 8, 60);
        compare("gap");

        // Overflow: 12 beats with output stalled.
        add_block(1, 0, 0, 1'b1);
        add_block(2, 4, 0, 1'b1);
        add_block(3, 8, 0, 1'b0);
        drain(2, 0, 40);
        chk("ovf_flag", s_if.o_overflow, 1);
`ifdef TRANSPOSE_SINK_STATS_EN
        chk("ovf_dropped", dropped_beats, 4);
`endif
        drain(0, 16, 80);
        compare("ovf");
        chk("ovf_sticky", s_if.o_overflow, 1);
`ifdef TRANSPOSE_SINK_STATS_EN
        chk("stats_blocks", blocks_done, 8);
`endif

        // Reset mid-drain after the third word.
        add_block(0, 0, 0, 1'b1);
        drain(0, 3, 40);
        exp_q = exp_q[0:2];
        compare("pre_rst");
        aresetn = 1'b0;
        tick();
        chk("mid_rst_valid", s_if.o_valid, 0);
        chk("mid_rst_data", s_if.o_data, 0);
        chk("mid_rst_last", s_if.o_last, 0);
        chk("mid_rst_overflow", s_if.o_overflow, 0);
        aresetn = 1'b1;
        add_block(7, 0, 0, 1'b1);
        drain(0, 8, 40);
        compare("post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
